// File: rtl/inf_tx.sv
// rtl/inf_tx.sv - NEC infrared transmitter: leader, 32 data bits, stop burst, repeat code, 38 kHz carrier.
// inf_env is active-low during bursts so it can be looped straight into the NEC receive path.
module inf_tx #(
  parameter int unsigned CNT_9MS    = 450000,
  parameter int unsigned CNT_4_5MS  = 225000,
  parameter int unsigned CNT_2_25MS = 112500,
  parameter int unsigned CNT_560US  = 28000,
  parameter int unsigned CNT_1_69MS = 84500,
  parameter int unsigned CNT_GAP    = 2000000,
  parameter int unsigned CAR_PERIOD = 1316,
  parameter int unsigned CAR_HIGH   = 439
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       rpt_start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       inf_env,
  output logic       inf_led,
  output logic       busy,
  output logic       done
);

  localparam int DW = 21;
  localparam int CW = 11;

  typedef enum logic [2:0] {
    IDLE, LEAD_BURST, LEAD_SPACE, BIT_BURST, BIT_SPACE, STOP_BURST, GAP
  } state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;   // 1 = repeat code
  logic [DW-1:0]   dur_q, dur_d, dur_last;
  logic [CW-1:0]   car_q, car_d;
  logic [5:0]      bit_q, bit_d;
  logic [31:0]     sr_q, sr_d;
  logic            env_q, env_d, led_q, led_d, busy_q, busy_d, done_q, done_d;
  logic            burst_d, phase_end;

  always_comb begin
    dur_last = DW'(CNT_560US - 1);
    case (state_q)
      LEAD_BURST: dur_last = DW'(CNT_9MS - 1);
      LEAD_SPACE: dur_last = mode_q ? DW'(CNT_2_25MS - 1) : DW'(CNT_4_5MS - 1);
      BIT_SPACE:  dur_last = sr_q[0] ? DW'(CNT_1_69MS - 1) : DW'(CNT_560US - 1);
      GAP:        dur_last = DW'(CNT_GAP - 1);
      default:    dur_last = DW'(CNT_560US - 1);
    endcase
  end

  assign phase_end = (dur_q == dur_last);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dur_d   = dur_q + DW'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        dur_d = '0;
        if (start) begin
          sr_d    = {~cmd, cmd, ~addr, addr};
          mode_d  = 1'b0;
          bit_d   = '0;
          state_d = LEAD_BURST;
        end else if (rpt_start) begin
          mode_d  = 1'b1;
          bit_d   = '0;
          state_d = LEAD_BURST;
        end
      end
      default: begin
        if (phase_end) begin
          dur_d = '0;
          case (state_q)
            LEAD_BURST: state_d = LEAD_SPACE;
            LEAD_SPACE: state_d = mode_q ? STOP_BURST : BIT_BURST;
            BIT_BURST:  state_d = BIT_SPACE;
            BIT_SPACE: begin
              sr_d    = sr_q >> 1;
              bit_d   = bit_q + 6'd1;
              state_d = (bit_q == 6'd31) ? STOP_BURST : BIT_BURST;
            end
            STOP_BURST: state_d = GAP;
            GAP: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default:    state_d = IDLE;
          endcase
        end
      end
    endcase

    // Outputs are computed from the next state so they line up with state_q.
    burst_d = (state_d == LEAD_BURST) || (state_d == BIT_BURST) || (state_d == STOP_BURST);
    if (!burst_d || (state_d != state_q))
      car_d = '0;
    else if (car_q == CW'(CAR_PERIOD - 1))
      car_d = '0;
    else
      car_d = car_q + CW'(1);
    env_d  = ~burst_d;
    led_d  = burst_d && (car_d < CW'(CAR_HIGH));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dur_q   <= '0;
      car_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      env_q   <= 1'b1;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dur_q   <= dur_d;
      car_q   <= car_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      env_q   <= env_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inf_env = env_q;
  assign inf_led = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_inf_tx.sv
// tb/tb_inf_tx.sv - directed vector bench for inf_tx with scaled-down timing parameters.
module tb_inf_tx;

  localparam int P9   = 40;
  localparam int P45  = 20;
  localparam int P225 = 10;
  localparam int P560 = 4;
  localparam int P169 = 12;
  localparam int PGAP = 30;
  localparam int PPER = 6;
  localparam int PHI  = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       start, rpt_start;
  logic [7:0] addr, cmd;
  logic       inf_env, inf_led, busy, done;

  int checks = 0;
  int failures = 0;

  int   exp_len[$];
  logic exp_val[$];
  int   obs_len[$];
  logic obs_val[$];

  typedef struct {
    string      name;
    logic       st;
    logic       rp;
    logic [7:0] a;
    logic [7:0] c;
    int         inj;
    int         exp_busy;
  } vec_t;

  vec_t vecs[4];

  inf_tx #(
    .CNT_9MS(P9), .CNT_4_5MS(P45), .CNT_2_25MS(P225), .CNT_560US(P560),
    .CNT_1_69MS(P169), .CNT_GAP(PGAP), .CAR_PERIOD(PPER), .CAR_HIGH(PHI)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .rpt_start(rpt_start),
    .addr(addr), .cmd(cmd), .inf_env(inf_env), .inf_led(inf_led),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic build_exp(input logic rep, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] data;
    data = {~c, c, ~a, a};
    exp_len.delete(); exp_val.delete();
    exp_val.push_back(1'b0); exp_len.push_back(P9);
    if (rep) begin
      exp_val.push_back(1'b1); exp_len.push_back(P225);
    end else begin
      exp_val.push_back(1'b1); exp_len.push_back(P45);
      for (int i = 0; i < 32; i++) begin
        exp_val.push_back(1'b0); exp_len.push_back(P560);
        exp_val.push_back(1'b1); exp_len.push_back(data[i] ? P169 : P560);
      end
    end
    exp_val.push_back(1'b0); exp_len.push_back(P560);
    exp_val.push_back(1'b1); exp_len.push_back(PGAP);
  endtask

  // Called at a negedge; drives the request for one cycle and records the envelope while busy.
  task automatic run_vec(input string nm, input logic st, input logic rp,
                         input logic [7:0] a, input logic [7:0] c,
                         input int inj, input int exp_busy);
    logic cur;
    int   len, bcnt, dcnt, car_bad, k, post_bad, nseg;
    obs_len.delete(); obs_val.delete();
    start = st; rpt_start = rp; addr = a; cmd = c;
    @(negedge sys_clk);
    start = 1'b0; rpt_start = 1'b0; addr = ~a; cmd = ~c;
    chk({nm, "_accept_busy"}, 32'(busy), 32'd1);
    chk({nm, "_accept_env"}, 32'(inf_env), 32'd0);
    cur = inf_env; len = 0; bcnt = 0; dcnt = 0; car_bad = 0; k = 0;
    while (busy && bcnt < 2000) begin
      bcnt++;
      if (inf_env !== cur) begin
        obs_val.push_back(cur); obs_len.push_back(len);
        cur = inf_env; len = 0; k = 0;
      end
      len++;
      if (inf_env == 1'b0) begin
        if (inf_led !== ((k % PPER) < PHI)) car_bad++;
        k++;
      end else if (inf_led !== 1'b0) begin
        car_bad++;
      end
      if (done) dcnt++;
      start = (inj != 0 && bcnt == inj);
      @(negedge sys_clk);
    end
    start = 1'b0;
    obs_val.push_back(cur); obs_len.push_back(len);
    chk({nm, "_busy_len"}, 32'(bcnt), 32'(exp_busy));
    chk({nm, "_done_early"}, 32'(dcnt), 32'd0);
    chk({nm, "_done_pulse"}, 32'(done), 32'd1);
    chk({nm, "_carrier"}, 32'(car_bad), 32'd0);
    build_exp(!st, a, c);
    chk({nm, "_seg_count"}, 32'(obs_len.size()), 32'(exp_len.size()));
    nseg = (obs_len.size() < exp_len.size()) ? obs_len.size() : exp_len.size();
    for (int i = 0; i < nseg; i++) begin
      chk($sformatf("%s_seg%0d_val", nm, i), 32'(obs_val[i]), 32'(exp_val[i]));
      chk($sformatf("%s_seg%0d_len", nm, i), 32'(obs_len[i]), 32'(exp_len[i]));
    end
    post_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || inf_env !== 1'b1 || inf_led !== 1'b0 || done !== 1'b0) post_bad++;
    end
    chk({nm, "_post_idle"}, 32'(post_bad), 32'd0);
  endtask

  initial begin
    int   bad, falls;
    logic prev;

    vecs[0] = '{"frame_00_16", 1'b1, 1'b0, 8'h00, 8'h16, 0,   478};
    vecs[1] = '{"repeat",      1'b0, 1'b1, 8'h00, 8'h00, 0,   84};
    vecs[2] = '{"both_gapreq", 1'b1, 1'b1, 8'hA5, 8'h3C, 460, 478};
    vecs[3] = '{"frame_ff_00", 1'b1, 1'b0, 8'hFF, 8'h00, 0,   478};

    sys_rst = 1'b1; start = 1'b0; rpt_start = 1'b0; addr = 8'h00; cmd = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", {28'd0, inf_env, inf_led, busy, done}, 32'b1000);
    sys_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (inf_env !== 1'b1 || inf_led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_100", 32'(bad), 32'd0);

    for (int v = 0; v < 4; v++)
      run_vec(vecs[v].name, vecs[v].st, vecs[v].rp, vecs[v].a, vecs[v].c,
              vecs[v].inj, vecs[v].exp_busy);

    // Abort during bit 10: leader is falling edge 1, bit n burst is falling edge n+2.
    start = 1'b1; addr = 8'h12; cmd = 8'h34;
    @(negedge sys_clk);
    start = 1'b0;
    prev = 1'b1; falls = 0;
    for (int i = 0; i < 2000 && falls < 12; i++) begin
      if (prev && !inf_env) falls++;
      prev = inf_env;
      if (falls < 12) @(negedge sys_clk);
    end
    chk("abort_reached_bit10", 32'(falls), 32'd12);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("abort_outputs", {28'd0, inf_env, inf_led, busy, done}, 32'b1000);
    run_vec("after_abort", 1'b1, 1'b0, 8'h12, 8'h34, 0, 478);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
